// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file access sequencer.
package rf_seq_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE,
    RD1,
    RD2,
    HOLD
  } state_e;

endpackage

// File: rtl/rf_access_sequencer.sv
// Serialises operand fetches and write-backs onto the single-port RF and
// presents both operands to execute once the 1-cycle read latency has elapsed.
module rf_access_sequencer #(
  parameter int unsigned ADDR_WIDTH = rf_seq_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = rf_seq_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_req_valid,
  output logic                  o_rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic                  i_use_rs2,
  output logic                  o_opnd_valid,
  input  logic                  i_opnd_ready,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_wb_valid,
  output logic                  o_wb_ready,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_rf_we,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata
);
  import rf_seq_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] Zero = ADDR_WIDTH'(REG_ZERO);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                  use_rs2_q, use_rs2_d;
  logic                  opnd_valid_q, opnd_valid_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      use_rs2_q    <= 1'b0;
      opnd_valid_q <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      use_rs2_q    <= use_rs2_d;
      opnd_valid_q <= opnd_valid_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    use_rs2_d      = use_rs2_q;
    opnd_valid_d   = opnd_valid_q;
    rs1_data_d     = rs1_data_q;
    rs2_data_d     = rs2_data_q;
    o_rd_req_ready = 1'b0;
    o_wb_ready     = 1'b0;
    o_rf_we        = 1'b0;
    o_rf_addr      = '0;
    o_rf_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        // Write-back wins the port; a pending fetch retries next cycle.
        if (i_wb_valid) begin
          o_wb_ready = 1'b1;
          if (i_wb_addr != Zero) begin
            o_rf_we    = 1'b1;
            o_rf_addr  = i_wb_addr;
            o_rf_wdata = i_wb_data;
          end
        end else if (i_rd_req_valid) begin
          o_rd_req_ready = 1'b1;
          rs1_d          = i_rs1;
          rs2_d          = i_rs2;
          use_rs2_d      = i_use_rs2;
          o_rf_addr      = i_rs1;
          state_d        = RD1;
        end
      end
      RD1: begin
        rs1_data_d = (rs1_q == Zero) ? '0 : i_rf_rdata;
        if (use_rs2_q) begin
          o_rf_addr = rs2_q;
          state_d   = RD2;
        end else begin
          rs2_data_d   = '0;
          opnd_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      RD2: begin
        rs2_data_d   = (rs2_q == Zero) ? '0 : i_rf_rdata;
        opnd_valid_d = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        // The port is free while operands wait, so write-backs drain here too.
        if (i_wb_valid) begin
          o_wb_ready = 1'b1;
          if (i_wb_addr != Zero) begin
            o_rf_we    = 1'b1;
            o_rf_addr  = i_wb_addr;
            o_rf_wdata = i_wb_data;
          end
        end
        if (i_opnd_ready) begin
          opnd_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_opnd_valid = opnd_valid_q;
  assign o_rs1_data   = rs1_data_q;
  assign o_rs2_data   = rs2_data_q;

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Bench for rf_access_sequencer: RF memory model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_rf_access_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rs1, rs2;
  logic          use_rs2;
  logic          opnd_valid, opnd_ready;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  int checks = 0;
  int errors = 0;

  rf_access_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .i_rd_req_valid (rd_req_valid),
    .o_rd_req_ready (rd_req_ready),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .i_use_rs2      (use_rs2),
    .o_opnd_valid   (opnd_valid),
    .i_opnd_ready   (opnd_ready),
    .o_rs1_data     (rs1_data),
    .o_rs2_data     (rs2_data),
    .i_wb_valid     (wb_valid),
    .o_wb_ready     (wb_ready),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .o_rf_we        (rf_we),
    .o_rf_addr      (rf_addr),
    .o_rf_wdata     (rf_wdata),
    .i_rf_rdata     (rf_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Physical register file: synchronous read, write on o_rf_we.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
    rf_rdata <= mem[rf_addr];
  end

  // Reference model: architectural registers plus the in-flight request.
  logic [DW-1:0] arch [32];
  int            ph;   // 0 idle, 1 fetching, 2 holding operands
  int            k;    // cycles since accept while fetching
  bit            m_use;
  logic [AW-1:0] m_rs2;
  logic [DW-1:0] m_e1, m_e2;
  logic          e_wbr, e_rdr, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      ph = 0;
      k  = 0;
      chk("reset_valid", opnd_valid, 0);
      chk("reset_rs1", rs1_data, 0);
      chk("reset_rs2", rs2_data, 0);
    end else begin
      e_wbr = 0; e_rdr = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      if (ph == 0 || ph == 2) begin
        e_wbr   = wb_valid;
        e_we    = wb_valid && (wb_addr != 0);
        e_wdata = e_we ? wb_data : '0;
        e_addr  = wb_valid ? wb_addr : '0;
        if (ph == 0 && !wb_valid && rd_req_valid) begin
          e_rdr  = 1;
          e_addr = rs1;
        end
      end else if (k == 1 && m_use) begin
        e_addr = m_rs2;
      end
      chk("wb_ready", wb_ready, e_wbr);
      chk("rd_req_ready", rd_req_ready, e_rdr);
      chk("rf_we", rf_we, e_we);
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_wdata", rf_wdata, e_wdata);
      chk("opnd_valid", opnd_valid, ph == 2);
      if (ph == 2) begin
        chk("rs1_data", rs1_data, m_e1);
        chk("rs2_data", rs2_data, m_e2);
      end
      // Advance to the state after the coming edge.
      if (e_we) arch[wb_addr] = wb_data;
      if (ph == 0) begin
        if (e_rdr) begin
          m_e1  = (rs1 == 0) ? '0 : arch[rs1];
          m_e2  = (use_rs2 && rs2 != 0) ? arch[rs2] : '0;
          m_use = use_rs2;
          m_rs2 = rs2;
          ph    = 1;
          k     = 1;
        end
      end else if (ph == 1) begin
        if (k == 1 && m_use) k = 2;
        else ph = 2;
      end else if (opnd_ready) begin
        ph = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
    tick();
    wb_valid = 0;
  endtask

  task automatic do_rd(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input bit u,
                       input int exp_stall, input int exp_lat,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                       input int bp, input bit bp_wb, input logic [AW-1:0] bpa,
                       input logic [DW-1:0] bpd);
    bit acc;
    bit got;
    int n;
    int lat;
    rd_req_valid = 1; rs1 = r1; rs2 = r2; use_rs2 = u;
    acc = 0; n = 0;
    while (!acc && n < 10) begin
      @(negedge clk); #2;
      acc = rd_req_ready;
      n++;
      tick();
      wb_valid = 0;
    end
    rd_req_valid = 0;
    chk("rd_accepted", acc, 1);
    chk("rd_accept_cycles", n, exp_stall);
    lat = 1; got = 0;
    while (!got && lat < 8) begin
      @(negedge clk); #2;
      if (opnd_valid) got = 1;
      else begin
        tick();
        lat++;
      end
    end
    chk("latency", lat, exp_lat);
    chk("lit_rs1", rs1_data, e1);
    chk("lit_rs2", rs2_data, e2);
    tick();
    for (int j = 0; j < bp; j++) begin
      if (j == 0 && bp_wb) begin
        wb_valid = 1; wb_addr = bpa; wb_data = bpd;
      end
      rd_req_valid = 1; rs1 = 5'd9;
      @(negedge clk); #2;
      chk("bp_valid", opnd_valid, 1);
      chk("bp_rs1", rs1_data, e1);
      chk("bp_rs2", rs2_data, e2);
      chk("bp_rd_ready", rd_req_ready, 0);
      tick();
      wb_valid = 0;
    end
    rd_req_valid = 0;
    opnd_ready = 1;
    @(negedge clk); #2;
    chk("consume_valid", opnd_valid, 1);
    tick();
    opnd_ready = 0;
    @(negedge clk); #2;
    chk("consumed", opnd_valid, 0);
    tick();
  endtask

  initial begin
    rst = 0;
    rd_req_valid = 0; rs1 = '0; rs2 = '0; use_rs2 = 0; opnd_ready = 0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]  = $urandom();
      arch[i] = mem[i];
    end
    mem[0]  = 32'hBAD0_0BAD;
    arch[0] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    tick();

    do_wb(5'd5, 32'h1234_5678);
    do_wb(5'd6, 32'hDEAD_BEEF);
    do_rd(5'd5, 5'd6, 1, 1, 3, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, '0, '0);

    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    @(negedge clk); #2;
    chk("x0_wb_ready", wb_ready, 1);
    chk("x0_rf_we", rf_we, 0);
    tick();
    wb_valid = 0;
    do_rd(5'd0, 5'd0, 1, 1, 3, 32'h0, 32'h0, 0, 0, '0, '0);

    do_wb(5'd7, 32'h42);
    do_rd(5'd7, 5'd6, 0, 1, 2, 32'h42, 32'h0, 0, 0, '0, '0);

    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h99;
    do_rd(5'd3, 5'd0, 0, 2, 2, 32'h99, 32'h0, 0, 0, '0, '0);

    do_rd(5'd5, 5'd6, 1, 1, 3, 32'h1234_5678, 32'hDEAD_BEEF, 5, 1, 5'd5, 32'h0);
    do_rd(5'd5, 5'd0, 0, 1, 2, 32'h0, 32'h0, 0, 0, '0, '0);

    // Reset while the second operand is being read.
    rd_req_valid = 1; rs1 = 5'd6; rs2 = 5'd7; use_rs2 = 1;
    @(negedge clk); #2;
    chk("rst_case_accept", rd_req_ready, 1);
    tick();
    rd_req_valid = 0;
    tick();
    rst = 0;
    #1;
    chk("rst_mid_valid", opnd_valid, 0);
    chk("rst_mid_rs1", rs1_data, 0);
    chk("rst_mid_rs2", rs2_data, 0);
    tick();
    rst = 1;
    do_rd(5'd7, 5'd3, 1, 1, 3, 32'h42, 32'h99, 0, 0, '0, '0);

    for (int c = 0; c < 3000; c++) begin
      rd_req_valid = 1'($urandom_range(0, 1));
      wb_valid     = ($urandom_range(0, 3) == 0);
      opnd_ready   = ($urandom_range(0, 2) == 0);
      use_rs2      = 1'($urandom_range(0, 1));
      rs1          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rs2          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wb_addr      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wb_data      = $urandom();
      rst          = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1; rd_req_valid = 0; wb_valid = 0; opnd_ready = 1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_access_sequencer.md
Name: rf_access_sequencer

Overview:
Upstream arbiter and sequencer for the single-port, synchronous-read register file. It serialises decode operand fetches (rs1, optional rs2) and write-back commits onto the one shared RF port. It hides the 1-cycle read latency, forces x0 reads to zero, and presents both operands together to execute over a valid/ready handshake.

Parameters:
ADDR_WIDTH, 5, register index width (32 registers).
DATA_WIDTH, 32, register data width.

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-low.
i_rd_req_valid  input  1  decode offers an operand fetch request.
o_rd_req_ready  output  1  fetch request accepted this cycle.
i_rs1  input  ADDR_WIDTH  source register 1 index.
i_rs2  input  ADDR_WIDTH  source register 2 index.
i_use_rs2  input  1  request needs rs2.
o_opnd_valid  output  1  operand pair valid.
i_opnd_ready  input  1  execute consumes operands.
o_rs1_data  output  DATA_WIDTH  rs1 value.
o_rs2_data  output  DATA_WIDTH  rs2 value (0 if not used).
i_wb_valid  input  1  write-back request.
o_wb_ready  output  1  write-back accepted this cycle.
i_wb_addr  input  ADDR_WIDTH  destination index.
i_wb_data  input  DATA_WIDTH  write-back data.
o_rf_we  output  1  RF write enable.
o_rf_addr  output  ADDR_WIDTH  RF address.
o_rf_wdata  output  DATA_WIDTH  RF write data.
i_rf_rdata  input  DATA_WIDTH  RF registered read data; reflects the address presented on the previous edge.

Behaviour:
- FSM states: IDLE, RD1, RD2, HOLD. Reset state is IDLE.
- Registered outputs at reset: o_opnd_valid=0, o_rs1_data=0, o_rs2_data=0. Latched rs1, rs2 and use_rs2 are also cleared.
- RF port outputs and ready signals are combinational from state and inputs. The default RF drive is o_rf_we=0, o_rf_addr=0, o_rf_wdata=0.
- IDLE:
  - Write-back has priority. If i_wb_valid: o_wb_ready=1 and o_rd_req_ready=0.
  - If i_wb_addr!=0: o_rf_we=1, o_rf_addr=i_wb_addr, o_rf_wdata=i_wb_data.
  - If i_wb_addr==0: the write is accepted and discarded (o_rf_we=0).
  - Else if i_rd_req_valid: o_rd_req_ready=1, latch i_rs1/i_rs2/i_use_rs2, drive o_rf_addr=i_rs1, go to RD1.
- RD1:
  - Capture rs1_data = (rs1==0) ? 0 : i_rf_rdata.
  - If use_rs2: drive o_rf_addr=rs2 and go to RD2.
  - Otherwise set rs2_data=0 and go to HOLD.
- RD2: capture rs2_data = (rs2==0) ? 0 : i_rf_rdata, then go to HOLD.
- HOLD:
  - o_opnd_valid=1. Data is stable until consumed.
  - On i_opnd_ready, go to IDLE and deassert o_opnd_valid.
  - Write-back is also accepted here with the same x0 rule; it does not alter the held operands.
- o_wb_ready=0 and o_rd_req_ready=0 in RD1 and RD2; o_rd_req_ready=0 in HOLD.
- Latency from request accept edge to o_opnd_valid: 2 cycles for one operand, 3 cycles for two operands.
- Ordering: a write accepted in IDLE reaches the RF before any later-accepted read, so no RAW bypass is needed.
- Simultaneous i_wb_valid and i_rd_req_valid in IDLE: write wins, and the read is accepted on a later IDLE cycle.
- Simultaneous opnd consume and write-back in HOLD: both complete in the same cycle.
- Reset mid-operation: return to IDLE immediately and clear captured data. The in-flight request is dropped and upstream must reissue.
- No combinational path from i_rf_rdata to any output.

Decomposition:
- Package rf_seq_pkg holds:
  - the state enum typedef (IDLE, RD1, RD2, HOLD);
  - the constant REG_ZERO = 0;
  - default widths ADDR_WIDTH/DATA_WIDTH.
- No sub-module. The FSM and capture registers form a single module.

Test Plan:
- Two-operand read after writes: write x5=0x1234_5678 and x6=0xDEAD_BEEF, then request rs1=5, rs2=6, use_rs2=1. Required: o_opnd_valid 3 cycles after accept, o_rs1_data=0x1234_5678, o_rs2_data=0xDEAD_BEEF.
- x0 handling: write-back to x0 with 0xFFFF_FFFF gives o_wb_ready=1 and o_rf_we=0. A following request rs1=0, rs2=0 returns both operands = 0.
- Single operand: request rs1=7 (x7=0x42), use_rs2=0. Required: valid 2 cycles after accept, rs1=0x42, rs2=0.
- Simultaneous wb and read in IDLE: wb x3=0x99 together with a read of rs1=3. Write is accepted first and the read is stalled one cycle; the returned rs1 must be 0x99.
- Backpressure: hold i_opnd_ready=0 for 5 cycles in HOLD while writing x5=0x0. Required: operands unchanged, o_rd_req_ready=0 throughout, return to IDLE on the ready cycle.
- Reset asserted in RD2: the next cycle shows o_opnd_valid=0 and zeroed data. After reset release, a new request completes normally.
